// File: rtl/pong_pkg.sv
// pong_pkg: shared types and defaults for the pong scoring logic.
//   state_t  : score_keeper FSM states (IDLE/HOLD/PLAY/OVER)
//   PLAYER_* : encoding used on serving_player
//   exits_t  : registered ball-exit strobes
//   DEF_*    : default parameter values for score_keeper
package pong_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    PLAY = 2'd2,
    OVER = 2'd3
  } state_t;

  localparam logic PLAYER_1 = 1'b0;
  localparam logic PLAYER_2 = 1'b1;

  localparam int DEF_WIN_SCORE   = 5;
  localparam int DEF_SCORE_W     = 4;
  localparam int DEF_HOLD_CYCLES = 64;
  localparam int DEF_HOLD_W      = 7;

  typedef struct packed {
    logic left;   // ball passed player 1's paddle
    logic right;  // ball passed player 2's paddle
  } exits_t;

endpackage

// File: rtl/serve_timer.sv
// serve_timer: loadable down-counter that times the serve delay.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : load value_i (wins over dec_i)
//   value_i       : value to load
//   dec_i         : decrement by one, sticks at zero
//   done_o        : count is zero
module serve_timer #(
  parameter int W = 7
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] value_i,
  input  logic         dec_i,
  output logic         done_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i)                   count_d = value_i;
    else if (dec_i && !done_o)    count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign done_o = (count_q == '0);

endmodule

// File: rtl/score_keeper.sv
// score_keeper: keeps both players' scores, decides goals and wins, and
// parks the ball during the serve delay and after game over.
//   BALL_CLOCK, RESET_N          : clock, asynchronous active-low reset
//   new_game                     : level, (re)start a game; beats exits
//   ball_exit_left/right         : level exit strobes from the ball engine
//   goal_player_*, win_player_*  : registered one-cycle event pulses
//   score_player_*               : current scores
//   ball_hold                    : ball must stay at the serve position
//   serving_player               : 0 = player 1, 1 = player 2
// Build option: define DEUCE_EN to require a two-point lead to win, with
// scores saturating at 2**SCORE_W-1 (a point at saturation always wins).
module score_keeper
  import pong_pkg::*;
#(
  parameter int WIN_SCORE   = DEF_WIN_SCORE,
  parameter int SCORE_W     = DEF_SCORE_W,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int HOLD_W      = DEF_HOLD_W
) (
  input  logic               BALL_CLOCK,
  input  logic               RESET_N,
  input  logic               new_game,
  input  logic               ball_exit_left,
  input  logic               ball_exit_right,
  output logic               goal_player_1,
  output logic               goal_player_2,
  output logic               win_player_1,
  output logic               win_player_2,
  output logic [SCORE_W-1:0] score_player_1,
  output logic [SCORE_W-1:0] score_player_2,
  output logic               ball_hold,
  output logic               serving_player
);

  localparam logic [SCORE_W-1:0] WIN_V     = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]  HOLD_LOAD = HOLD_W'(HOLD_CYCLES - 1);

  state_t             state_q, state_d;
  logic [SCORE_W-1:0] s1_q, s1_d, s2_q, s2_d;
  logic               serve_q, serve_d;
  logic               g1_q, g1_d, g2_q, g2_d, w1_q, w1_d, w2_q, w2_d;
  exits_t             exit_q, exit_d;
  logic               tmr_load, tmr_dec, tmr_done;

  // Point decode works on the registered exits, giving the two-edge
  // exit-to-pulse latency. Exactly one exit must be high to count.
  logic               point, p1_scores, win;
  logic [SCORE_W-1:0] scorer, nxt;

  assign point     = (state_q == PLAY) && !new_game && (exit_q.left ^ exit_q.right);
  assign p1_scores = exit_q.right;
  assign scorer    = p1_scores ? s1_q : s2_q;

`ifdef DEUCE_EN
  logic [SCORE_W-1:0] opp;
  logic               sat;
  assign opp = p1_scores ? s2_q : s1_q;
  assign sat = (scorer == '1);
  assign nxt = sat ? scorer : scorer + 1'b1;
  // Widened compare so opp+2 cannot wrap.
  assign win = sat || ((nxt >= WIN_V) &&
               ({1'b0, nxt} >= ({1'b0, opp} + (SCORE_W+1)'(2))));
`else
  // Scores only move below WIN_SCORE, so the increment cannot wrap.
  assign nxt = scorer + 1'b1;
  assign win = (nxt == WIN_V);
`endif

  serve_timer #(.W(HOLD_W)) u_timer (
    .clk_i   (BALL_CLOCK),
    .rst_ni  (RESET_N),
    .load_i  (tmr_load),
    .value_i (HOLD_LOAD),
    .dec_i   (tmr_dec),
    .done_o  (tmr_done)
  );

  always_comb begin
    state_d      = state_q;
    s1_d         = s1_q;
    s2_d         = s2_q;
    serve_d      = serve_q;
    g1_d         = 1'b0;
    g2_d         = 1'b0;
    w1_d         = 1'b0;
    w2_d         = 1'b0;
    tmr_load     = 1'b0;
    tmr_dec      = 1'b0;
    // Only exits seen while playing (and not overridden) enter the pipe.
    exit_d.left  = (state_q == PLAY) && ball_exit_left  && !new_game;
    exit_d.right = (state_q == PLAY) && ball_exit_right && !new_game;

    if (new_game) begin
      state_d  = HOLD;
      s1_d     = '0;
      s2_d     = '0;
      serve_d  = PLAYER_1;
      tmr_load = 1'b1;
    end else begin
      case (state_q)
        HOLD: begin
          if (tmr_done) state_d = PLAY;
          else          tmr_dec = 1'b1;
        end
        PLAY: begin
          if (point) begin
            if (p1_scores) begin
              s1_d    = nxt;
              serve_d = PLAYER_2;
              w1_d    = win;
              g1_d    = !win;
            end else begin
              s2_d    = nxt;
              serve_d = PLAYER_1;
              w2_d    = win;
              g2_d    = !win;
            end
            if (win) begin
              state_d = OVER;
            end else begin
              state_d  = HOLD;
              tmr_load = 1'b1;
            end
          end
        end
        default: ;  // IDLE/OVER wait for new_game
      endcase
    end
  end

  always_ff @(posedge BALL_CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      s1_q    <= '0;
      s2_q    <= '0;
      serve_q <= PLAYER_1;
      g1_q    <= 1'b0;
      g2_q    <= 1'b0;
      w1_q    <= 1'b0;
      w2_q    <= 1'b0;
      exit_q  <= '0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      serve_q <= serve_d;
      g1_q    <= g1_d;
      g2_q    <= g2_d;
      w1_q    <= w1_d;
      w2_q    <= w2_d;
      exit_q  <= exit_d;
    end
  end

  assign goal_player_1  = g1_q;
  assign goal_player_2  = g2_q;
  assign win_player_1   = w1_q;
  assign win_player_2   = w2_q;
  assign score_player_1 = s1_q;
  assign score_player_2 = s2_q;
  assign serving_player = serve_q;
  assign ball_hold      = (state_q != PLAY);

endmodule

// File: tb/tb_score_keeper.sv
module tb_score_keeper;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       new_game = 1'b0;
  logic       exl = 1'b0;
  logic       exr = 1'b0;
  logic       g1, g2, w1, w2, hold, serve;
  logic [3:0] s1, s2;
  logic [3:0] pulses;

  int tests = 0;
  int fails = 0;

  assign pulses = {g1, g2, w1, w2};

  score_keeper dut (
    .BALL_CLOCK      (clk),
    .RESET_N         (rst_n),
    .new_game        (new_game),
    .ball_exit_left  (exl),
    .ball_exit_right (exr),
    .goal_player_1   (g1),
    .goal_player_2   (g2),
    .win_player_1    (w1),
    .win_player_2    (w2),
    .score_player_1  (s1),
    .score_player_2  (s2),
    .ball_hold       (hold),
    .serving_player  (serve)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for PLAY; a timeout counts as a failed comparison.
  task automatic wait_play;
    int n;
    n = 0;
    while (hold === 1'b1 && n < 300) begin
      tick;
      n++;
    end
    tests++;
    if (hold !== 1'b0) begin
      fails++;
      $display("FAIL wait_play: ball_hold=%b after %0d cycles, required 0", hold, n);
    end
  endtask

  // Number of samples (one per cycle, starting now) with ball_hold high.
  task automatic count_hold(output int n);
    n = 0;
    while (hold === 1'b1 && n < 300) begin
      n++;
      tick;
    end
  endtask

  // One-cycle exit pulse in PLAY; returns once the event pulse is visible.
  task automatic score(input bit right);
    wait_play;
    if (right) exr = 1'b1; else exl = 1'b1;
    tick;
    exr = 1'b0;
    exl = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    tick;
    tick;
    tests++;
    if (pulses !== 4'b0 || s1 !== 4'd0 || s2 !== 4'd0 || hold !== 1'b1 || serve !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: pulses=%b s1=%0d s2=%0d hold=%b serve=%b, required 0000 0 0 1 0",
               pulses, s1, s2, hold, serve);
    end
    rst_n = 1'b1;
    repeat (5) tick;
    tests++;
    if (hold !== 1'b1 || pulses !== 4'b0) begin
      fails++;
      $display("FAIL idle_hold: hold=%b pulses=%b, required 1 0000", hold, pulses);
    end
  endtask

  task automatic test_start;
    int n;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    count_hold(n);
    tests++;
    if (n != 64) begin
      fails++;
      $display("FAIL start_hold_len: got %0d cycles, required 64", n);
    end
    tests++;
    if (hold !== 1'b0 || s1 !== 4'd0 || s2 !== 4'd0) begin
      fails++;
      $display("FAIL start_play: hold=%b s1=%0d s2=%0d, required 0 0 0", hold, s1, s2);
    end
  endtask

  task automatic test_goal;
    int n;
    exr = 1'b1;
    tick;
    exr = 1'b0;
    // Exit has been sampled but the result is one edge later.
    tests++;
    if (pulses !== 4'b0 || s1 !== 4'd0) begin
      fails++;
      $display("FAIL goal_latency: pulses=%b s1=%0d, required 0000 0", pulses, s1);
    end
    tick;
    tests++;
    if (pulses !== 4'b1000 || s1 !== 4'd1 || s2 !== 4'd0 || serve !== 1'b1 || hold !== 1'b1) begin
      fails++;
      $display("FAIL goal_p1: pulses=%b s1=%0d s2=%0d serve=%b hold=%b, required 1000 1 0 1 1",
               pulses, s1, s2, serve, hold);
    end
    tick;
    tests++;
    if (pulses !== 4'b0) begin
      fails++;
      $display("FAIL goal_pulse_width: pulses=%b, required 0000", pulses);
    end
    // One of the 64 hold cycles was already spent above.
    count_hold(n);
    tests++;
    if (n != 63) begin
      fails++;
      $display("FAIL goal_hold_len: got %0d remaining cycles, required 63", n);
    end
  endtask

  task automatic test_win;
    bit seen;
    for (int k = 1; k <= 4; k++) begin
      score(1'b0);
      tests++;
      if (pulses !== 4'b0100 || s2 !== 4'(k) || serve !== 1'b0) begin
        fails++;
        $display("FAIL goal_p2_%0d: pulses=%b s2=%0d serve=%b, required 0100 %0d 0",
                 k, pulses, s2, serve, k);
      end
    end
    score(1'b0);
    tests++;
    if (pulses !== 4'b0001 || s2 !== 4'd5 || s1 !== 4'd1 || hold !== 1'b1) begin
      fails++;
      $display("FAIL win_p2: pulses=%b s1=%0d s2=%0d hold=%b, required 0001 1 5 1",
               pulses, s1, s2, hold);
    end
    tick;
    tests++;
    if (pulses !== 4'b0) begin
      fails++;
      $display("FAIL win_pulse_width: pulses=%b, required 0000", pulses);
    end
    seen = 1'b0;
    exl = 1'b1;
    for (int i = 0; i < 100; i++) begin
      exr = i[0];
      tick;
      if (pulses !== 4'b0) seen = 1'b1;
    end
    exl = 1'b0;
    exr = 1'b0;
    tick;
    tests++;
    if (seen || s1 !== 4'd1 || s2 !== 4'd5 || hold !== 1'b1) begin
      fails++;
      $display("FAIL over_frozen: pulse_seen=%b s1=%0d s2=%0d hold=%b, required 0 1 5 1",
               seen, s1, s2, hold);
    end
  endtask

  task automatic test_both_exits;
    bit seen;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    wait_play;
    seen = 1'b0;
    exl = 1'b1;
    exr = 1'b1;
    tick;
    exl = 1'b0;
    exr = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (pulses !== 4'b0) seen = 1'b1;
      tick;
    end
    tests++;
    if (seen || s1 !== 4'd0 || s2 !== 4'd0 || hold !== 1'b0) begin
      fails++;
      $display("FAIL both_exits: pulse_seen=%b s1=%0d s2=%0d hold=%b, required 0 0 0 0",
               seen, s1, s2, hold);
    end
  endtask

  task automatic test_new_game_priority;
    score(1'b1);
    tests++;
    if (s1 !== 4'd1 || serve !== 1'b1) begin
      fails++;
      $display("FAIL prio_setup: s1=%0d serve=%b, required 1 1", s1, serve);
    end
    wait_play;
    new_game = 1'b1;
    exr = 1'b1;
    tick;
    new_game = 1'b0;
    exr = 1'b0;
    tests++;
    if (s1 !== 4'd0 || s2 !== 4'd0 || pulses !== 4'b0 || hold !== 1'b1 || serve !== 1'b0) begin
      fails++;
      $display("FAIL new_game_prio: s1=%0d s2=%0d pulses=%b hold=%b serve=%b, required 0 0 0000 1 0",
               s1, s2, pulses, hold, serve);
    end
    tick;
    tests++;
    if (pulses !== 4'b0 || s1 !== 4'd0) begin
      fails++;
      $display("FAIL new_game_drop: pulses=%b s1=%0d, required 0000 0", pulses, s1);
    end
    // Score again so reset has non-reset values to clear mid-HOLD.
    score(1'b1);
    repeat (10) tick;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (s1 !== 4'd0 || s2 !== 4'd0 || serve !== 1'b0 || hold !== 1'b1 || pulses !== 4'b0) begin
      fails++;
      $display("FAIL async_reset: s1=%0d s2=%0d serve=%b hold=%b pulses=%b, required 0 0 0 1 0000",
               s1, s2, serve, hold, pulses);
    end
    repeat (3) tick;
    rst_n = 1'b1;
    repeat (100) tick;
    tests++;
    if (hold !== 1'b1) begin
      fails++;
      $display("FAIL reset_to_idle: hold=%b after 100 cycles, required 1", hold);
    end
  endtask

  task automatic test_endgame;
    new_game = 1'b1;
    tick;
    new_game = 1'b0;
    for (int k = 0; k < 4; k++) begin
      score(1'b1);
      score(1'b0);
    end
    tests++;
    if (s1 !== 4'd4 || s2 !== 4'd4) begin
      fails++;
      $display("FAIL four_all: s1=%0d s2=%0d, required 4 4", s1, s2);
    end
    score(1'b1);
`ifdef DEUCE_EN
    tests++;
    if (pulses !== 4'b1000 || s1 !== 4'd5) begin
      fails++;
      $display("FAIL deuce_no_lead: pulses=%b s1=%0d, required 1000 5", pulses, s1);
    end
    score(1'b1);
    tests++;
    if (pulses !== 4'b0010 || s1 !== 4'd6 || s2 !== 4'd4) begin
      fails++;
      $display("FAIL deuce_win: pulses=%b s1=%0d s2=%0d, required 0010 6 4", pulses, s1, s2);
    end
`else
    tests++;
    if (pulses !== 4'b0010 || s1 !== 4'd5 || s2 !== 4'd4) begin
      fails++;
      $display("FAIL first_to_win: pulses=%b s1=%0d s2=%0d, required 0010 5 4", pulses, s1, s2);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_start;
    test_goal;
    test_win;
    test_both_exits;
    test_new_game_priority;
    test_endgame;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
